// File: rtl/trng_pkg.sv
// Shared types and serial framing constants for the TRNG serial path.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/trng_serial_tx_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/trng_serial_tx.sv
// Byte-serial 8N1 transmitter with RTS flow control and frame-start pulse.
module trng_serial_tx
    import trng_pkg::*;
#(
    parameter int CLK_DIV     = 868,
    parameter int FRAME_BYTES = 16384
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_dat,
    input  logic       i_write,
    input  logic       i_serial_rts_n,
    output logic       o_ready,
    output logic       o_serial_data,
    output logic       o_new_frame
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int FW = $clog2(FRAME_BYTES);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t state_q, state_d;

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q;
    logic          full_q;
    logic [FW-1:0] frame_q;
    logic          line_q, line_d;
    logic          new_frame_q;
    logic          rts_sync;
    logic          cts;
    logic          tick;
    logic          start_ok;
    logic          load;
    logic          accept;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rts_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (i_serial_rts_n),
        .o_q    (rts_sync)
    );

    assign cts      = ~rts_sync;
    assign tick     = (div_q == DIV_LAST);
    assign start_ok = full_q & cts;
    assign accept   = i_write & ~full_q;
    // cts only matters at byte boundaries: idle, or the last STOP cycle
    assign load     = start_ok &
                      ((state_q == IDLE) | ((state_q == STOP) & tick));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_ok) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_q == BIT_LAST) state_d = STOP;
            STOP:  if (tick) state_d = start_ok ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d   = div_q + DW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = 1'b1;
        if (state_q == IDLE || tick || state_d != state_q) begin
            div_d = '0;
        end
        if (state_d == DATA && state_q != DATA) begin
            bit_d = '0;
        end else if (state_q == DATA && tick) begin
            bit_d = bit_q + 3'd1;
        end
        if (load) begin
            shift_d = hold_q;
        end else if (state_q == DATA && tick) begin
            shift_d = {1'b0, shift_q[7:1]};
        end
        unique case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            frame_q     <= '0;
            line_q      <= 1'b1;
            new_frame_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            line_q      <= line_d;
            new_frame_q <= load & (frame_q == '0);
            if (load) begin
                full_q  <= 1'b0;
                frame_q <= frame_q + FW'(1);
            end else if (accept) begin
                full_q  <= 1'b1;
            end
            if (accept) begin
                hold_q <= i_dat;
            end
        end
    end

    assign o_ready       = ~full_q;
    assign o_serial_data = line_q;
    assign o_new_frame   = new_frame_q;

endmodule

// File: doc/trng_serial_tx.md
# trng_serial_tx

Byte-serial transmitter downstream of the TRNG readout path. Accepts one byte at a time through a ready/write handshake and serialises it LSB-first as 8N1 on `o_serial_data`. A new byte starts only while the host's active-low RTS line is asserted. Bytes are grouped into fixed-size frames, and a one-cycle pulse marks the start of each frame for the top-level frame counter.

## Interface
- `CLK_DIV`, default 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `FRAME_BYTES`, default 16384: bytes per frame; must be a power of two ≥ 2.
- `i_clk`  in  1  single system clock; all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_dat`  in  8  byte to send; sampled when `i_write & o_ready`.
- `i_write`  in  1  write strobe; ignored while `o_ready`=0.
- `i_serial_rts_n`  in  1  host flow control, active low, asynchronous to `i_clk`.
- `o_ready`  out  1  holding register empty; a write is accepted this cycle.
- `o_serial_data`  out  1  serial line, registered, idle high.
- `o_new_frame`  out  1  one-cycle pulse when the first byte of a frame starts.

## Operation
- **RTS synchroniser:** `i_serial_rts_n` passes through a 2-flop synchroniser to give `cts` (`cts` = ~synchronised value). The synchroniser resets to "not asserted".
- **Holding register:** one 8-bit register plus a `full` flag.
  - An accepted write sets `full`.
  - Transfer into the shift register clears `full`.
  - `o_ready` = ~`full`.
  - `i_write` while `full` is dropped. No overwrite, no error.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when `full & cts`. The holding register loads the shift register and `full` clears on the same edge.
  - START: line drives 0 for CLK_DIV cycles, then → DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each. A 3-bit bit index counts 0..7, then → STOP.
  - STOP: line drives 1 for CLK_DIV cycles. At the end of STOP:
    - if `full & cts`, go straight to START and load the next byte (no idle gap);
    - otherwise go to IDLE.
- **Flow control:** `cts` is evaluated only at byte boundaries (IDLE, or the last cycle of STOP). Deasserting RTS mid-byte never truncates a byte; the current byte completes, and the next start is held off.
- **Divider:** a counter of width $clog2(CLK_DIV).
  - Cleared on each state entry.
  - Counts 0..CLK_DIV-1.
  - The state/bit advances when it reaches CLK_DIV-1.
- **Frame counter:** width $clog2(FRAME_BYTES), incremented when a byte starts (entry to START). It wraps modulo FRAME_BYTES.
  - `o_new_frame` pulses on the start edge of a byte when the counter equals 0 before incrementing.
  - The first byte after reset therefore produces a pulse.

## Timing
- **Reset values (asynchronous):**
  - `o_serial_data`=1, `o_ready`=1, `o_new_frame`=0;
  - FSM=IDLE, `full`=0, frame counter=0, divider=0, `cts`=0.
- **Reset mid-byte:** the line returns high immediately, the byte is lost, and the pending holding byte is discarded.
- **Latency:**
  - Write accepted at edge t. `full`=1 from t.
  - If `cts`=1, the start bit drives 0 from edge t+1, and `o_ready` returns to 1 at the same edge t+1.
  - `o_new_frame` is high for the cycle following edge t+1 when applicable.
- **Byte duration:** exactly 10·CLK_DIV cycles, start edge to the next start edge when back-to-back.
- **RTS timing:** an RTS assertion becomes visible to the FSM 2 edges after it is stable at the pin.
- **Simultaneous write and transfer:** `o_ready` is 0 at the transfer edge (`full`=1), so a write and a transfer cannot coincide. At most 2 bytes are in flight: one shifting, one held.

## Structure
- **Package `trng_pkg`:** FSM state enum `tx_state_t` {IDLE, START, DATA, STOP} and the serial frame constants (DATA_BITS=8, STOP_BITS=1).
- **Sub-module `sync_2ff`:** generic 1-bit 2-flop synchroniser with async active-high reset and a reset-value parameter. It is reused for any other asynchronous inputs in the top level.
- **Everything else is in one module:** FSM, divider, shift register, holding register, frame counter.

## Test plan
- **Single byte** (CLK_DIV=4, RTS_n=0, write 0xA5):
  - line = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles;
  - `o_new_frame` pulses once;
  - `o_ready` is low for exactly 1 cycle.
- **Back-to-back** (writes 0x00 then 0xFF, the second as soon as `o_ready`=1): two bytes with no idle cycle, 80 cycles start-to-start end.
- **Flow control** (RTS_n=1, write 0x3C):
  - line stays 1 and `o_ready` stays 0 for 100 cycles;
  - RTS_n→0 gives a start bit 3 edges later.
  - Deasserting RTS during DATA: the byte completes, and the next held byte waits.
- **Frame wrap** (FRAME_BYTES=4, send 9 bytes): `o_new_frame` pulses on bytes 1, 5 and 9 only.
- **Dropped write** (`i_write` held high with changing data while `full`=1): only the first value and the value accepted after `o_ready` rises are transmitted.
- **Async reset mid-DATA:**
  - `o_serial_data`=1 without waiting for a clock edge, `o_ready`=1;
  - the next write after reset starts cleanly and pulses `o_new_frame`.
